safety_err_collector: RTL and testbench
=======================================

SAFETY_ERR_COLLECTOR -- requirements
Module: safety_err_collector

Interface
REQ-001 Parameter NUM_SRC, default 4: number of dual-rail error sources collected.
REQ-002 Parameter PERSIST, default 2, range 1..15: consecutive cycles an error must be present before it is latched.
REQ-003 Parameter DR_TOL, default 2, range 1..15: consecutive cycles of dual-rail disagreement tolerated before a pair fault is declared.
REQ-004 Parameter CNT_W, default 8: width of the error event counter.
REQ-005 ACLK  in  1  single clock; all state is updated on its rising edge.
REQ-006 RESETN_ACLK  in  1  reset, asynchronous assert, active-low.
REQ-007 I_ERR  in  NUM_SRC  error rail per source, driven by an upstream parity comparator.
REQ-008 I_ERR_B  in  NUM_SRC  complementary rail per source; valid only when equal to ~I_ERR.
REQ-009 I_MASK  in  NUM_SRC  1 = source excluded from O_IRQ (it is still latched and still pair-checked).
REQ-010 I_CLR  in  1  single-cycle clear strobe.
REQ-011 I_CLR_SEL  in  NUM_SRC  status bits cleared when I_CLR=1.
REQ-012 O_ERR_STATUS  out  NUM_SRC  sticky latched error per source.
REQ-013 O_IRQ  out  1  registered OR of O_ERR_STATUS & ~I_MASK.
REQ-014 O_FATAL / O_FATAL_B  out  1 / 1  dual-rail fatal indication; O_FATAL_B is ~O_FATAL at all times outside reset.
REQ-015 O_STATE  out  2  FSM state, for debug.

Function
REQ-016 I_ERR and I_ERR_B shall pass through a 1-flop input register before any evaluation.
REQ-017 A registered pair (e,eb)=(1,0) is an error; (0,1) is clean; e==eb is disagreement.
REQ-018 Per-source persistence counter: increment on each error cycle, reset to 0 on any non-error cycle; the status bit sets on the edge where the count reaches PERSIST. With PERSIST=1 the status bit sets 2 edges after input change.
REQ-019 Per-source disagreement counter: increment on each disagreement cycle, reset to 0 otherwise; reaching DR_TOL sets pair_fault for that source. Disagreement cycles never advance the persistence counter.
REQ-020 Counters saturate; no wrap-around.
REQ-021 Clear: O_ERR_STATUS[i] goes to 0 on the edge after I_CLR=1 with I_CLR_SEL[i]=1. If a set occurs on the same edge, set wins.
REQ-022 O_IRQ shall follow O_ERR_STATUS & ~I_MASK with one cycle of registered latency.
REQ-023 FSM states: IDLE (00), ERROR (01), FATAL (10). IDLE->ERROR when any status bit is 1. ERROR->IDLE when all status bits are 0. IDLE/ERROR->FATAL when any pair_fault is set. FATAL is exited only by reset.
REQ-024 FATAL state: O_FATAL=1, O_FATAL_B=0; status latching and clearing continue unchanged.
REQ-025 Pair-fault detection has priority over the ERROR transition on the same edge.
REQ-026 I_MASK does not affect latching, the FSM, or fatal detection.

Reset
REQ-027 While RESETN_ACLK=0: all counters 0, O_ERR_STATUS=0, O_IRQ=0, O_FATAL=0, O_FATAL_B=1, state IDLE, input register loaded with the clean pair (0,1).
REQ-028 Reset asserted mid-operation, including in FATAL, returns to the REQ-027 values immediately (asynchronous). Release is synchronous to ACLK.

Configuration
REQ-029 Macro SAFETY_ERR_COLLECTOR_CNT_EN.
- Defined: adds output O_ERR_CNT (CNT_W bits) and input I_CNT_CLR (1 bit).
- O_ERR_CNT increments by 1 on each edge where at least one status bit rises 0->1, and saturates at all-ones.
- I_CNT_CLR=1 zeroes the counter on the next edge; if an increment occurs on the same edge, the clear wins.
- Undefined: O_ERR_CNT, I_CNT_CLR and the counter logic are absent; all other behaviour is identical.

Structure
REQ-030 Package safety_err_pkg shall hold: the state enum (IDLE/ERROR/FATAL), the 4-bit counter width for PERSIST/DR_TOL, and the pair encodings (ERR=2'b10, CLEAN=2'b01).
REQ-031 Sub-module safety_err_filter, instantiated NUM_SRC times, shall contain the input register, the persistence counter, the disagreement counter and the pair_fault flag. The top level holds the status, FSM, IRQ and event counter.

Verification
REQ-032 Source 1 pair (1,0) held 2 cycles, PERSIST=2 -> O_ERR_STATUS=4'b0010; O_IRQ=1 one cycle later; state ERROR.
REQ-033 Source 0 pair (1,0) held 1 cycle, then clean, PERSIST=2 -> status stays 0; O_IRQ stays 0.
REQ-034 Status 4'b0011, I_MASK=4'b0011 -> O_IRQ=0 and state ERROR; then I_CLR=1 with I_CLR_SEL=4'b0011 -> status 0 and state IDLE next edge.
REQ-035 Source 2 pair (1,1) held 2 cycles, DR_TOL=2 -> O_FATAL=1, O_FATAL_B=0, state FATAL; I_CLR has no effect on state; RESETN_ACLK pulse -> IDLE, O_FATAL_B=1.
REQ-036 Source 3 error persists on the same edge that I_CLR targets source 3 -> status[3] stays 1.
REQ-037 With SAFETY_ERR_COLLECTOR_CNT_EN and CNT_W=2: 5 distinct status rise events -> O_ERR_CNT=3 (saturated); I_CNT_CLR=1 -> O_ERR_CNT=0.

Source files
------------

// File: rtl/safety_err_pkg.sv
// Shared types and encodings for the safety error collector.
package safety_err_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ERROR = 2'b01,
    FATAL = 2'b10
  } state_e;

  localparam int CTR_W = 4;
  typedef logic [CTR_W-1:0] ctr_t;

  localparam logic [1:0] PAIR_ERR   = 2'b10;
  localparam logic [1:0] PAIR_CLEAN = 2'b01;

  function automatic ctr_t sat_inc(input ctr_t v);
    return (v == '1) ? v : v + ctr_t'(1);
  endfunction

endpackage

// File: rtl/safety_err_filter.sv
// Per-source front end: registers one dual-rail pair and qualifies it into
// a persistence-filtered set request and a sticky pair-fault flag.
module safety_err_filter
  import safety_err_pkg::*;
#(
  parameter int PERSIST = 2,
  parameter int DR_TOL  = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_err,
  input  logic i_err_b,
  output logic set_o,
  output logic pair_fault_o
);

  localparam ctr_t PERSIST_C = ctr_t'(PERSIST);
  localparam ctr_t DR_TOL_C  = ctr_t'(DR_TOL);

  logic [1:0] pair_q, pair_d;
  ctr_t       pers_q, pers_d;
  ctr_t       dr_q, dr_d;
  logic       fault_q, fault_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pair_d = {i_err, i_err_b};
    pers_d = '0;
    dr_d   = '0;
    if (pair_q == PAIR_ERR)     pers_d = sat_inc(pers_q);
    if (pair_q[1] == pair_q[0]) dr_d   = sat_inc(dr_q);
    fault_d      = fault_q | (dr_d >= DR_TOL_C);
    // Set request is live on the edge the count reaches PERSIST.
    set_o        = (pers_d >= PERSIST_C);
    pair_fault_o = fault_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample together.
    if (!rst_n) begin
      pair_q  <= PAIR_CLEAN;
      pers_q  <= '0;
      dr_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      pair_q  <= pair_d;
      pers_q  <= pers_d;
      dr_q    <= dr_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: rtl/safety_err_collector.sv
// Safety error collector: sticky status, masked IRQ, IDLE/ERROR/FATAL FSM.
// Define SAFETY_ERR_COLLECTOR_CNT_EN to add the saturating error event counter.
module safety_err_collector
  import safety_err_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int PERSIST = 2,
  parameter int DR_TOL  = 2,
  parameter int CNT_W   = 8
) (
  input  logic               ACLK,
  input  logic               RESETN_ACLK,
  input  logic [NUM_SRC-1:0] I_ERR,
  input  logic [NUM_SRC-1:0] I_ERR_B,
  input  logic [NUM_SRC-1:0] I_MASK,
  input  logic               I_CLR,
  input  logic [NUM_SRC-1:0] I_CLR_SEL,
`ifdef SAFETY_ERR_COLLECTOR_CNT_EN
  input  logic               I_CNT_CLR,
  output logic [CNT_W-1:0]   O_ERR_CNT,
`endif
  output logic [NUM_SRC-1:0] O_ERR_STATUS,
  output logic               O_IRQ,
  output logic               O_FATAL,
  output logic               O_FATAL_B,
  output logic [1:0]         O_STATE
);

  logic [NUM_SRC-1:0] set_vec;
  logic [NUM_SRC-1:0] fault_vec;
  logic [NUM_SRC-1:0] status_q, status_d;
  logic               irq_q, irq_d;
  state_e             state_q;
  logic               fatal_q, fatal_b_q;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    safety_err_filter #(
      .PERSIST (PERSIST),
      .DR_TOL  (DR_TOL)
    ) u_filter (
      .clk          (ACLK),
      .rst_n        (RESETN_ACLK),
      .i_err        (I_ERR[g]),
      .i_err_b      (I_ERR_B[g]),
      .set_o        (set_vec[g]),
      .pair_fault_o (fault_vec[g])
    );
  end

  // Set is OR-ed after the clear so a coincident set wins.
  always_comb begin
    status_d = (status_q & ~(I_CLR ? I_CLR_SEL : '0)) | set_vec;
    irq_d    = |(status_q & ~I_MASK);
  end

  always_ff @(posedge ACLK or negedge RESETN_ACLK) begin
    if (!RESETN_ACLK) begin
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      irq_q    <= irq_d;
    end
  end

  // FSM follows the next-cycle status so state and status move on the same edge.
  always_ff @(posedge ACLK or negedge RESETN_ACLK) begin
    if (!RESETN_ACLK) begin
      state_q   <= IDLE;
      fatal_q   <= 1'b0;
      fatal_b_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE, ERROR: begin
          if (|fault_vec) begin
            state_q   <= FATAL;
            fatal_q   <= 1'b1;
            fatal_b_q <= 1'b0;
          end else if (|status_d) begin
            state_q <= ERROR;
          end else begin
            state_q <= IDLE;
          end
        end
        FATAL: begin
          state_q   <= FATAL;
          fatal_q   <= 1'b1;
          fatal_b_q <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          fatal_q   <= 1'b0;
          fatal_b_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef SAFETY_ERR_COLLECTOR_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise;

  always_comb begin
    rise  = |(status_d & ~status_q);
    cnt_d = cnt_q;
    if (I_CNT_CLR)                cnt_d = '0;
    else if (rise && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge ACLK or negedge RESETN_ACLK) begin
    if (!RESETN_ACLK) cnt_q <= '0;
    else              cnt_q <= cnt_d;
  end

  assign O_ERR_CNT = cnt_q;
`endif

  assign O_ERR_STATUS = status_q;
  assign O_IRQ        = irq_q;
  assign O_FATAL      = fatal_q;
  assign O_FATAL_B    = fatal_b_q;
  assign O_STATE      = state_q;

endmodule

// File: tb/tb_safety_err_collector.sv
// Directed scoreboard bench for safety_err_collector (PERSIST=2, DR_TOL=2).
module tb_safety_err_collector;
  import safety_err_pkg::*;

  localparam int N = 4;
`ifdef SAFETY_ERR_COLLECTOR_CNT_EN
  localparam int TB_CNT_W = 2;
`else
  localparam int TB_CNT_W = 8;
`endif

  logic         ACLK = 1'b0;
  logic         RESETN_ACLK;
  logic [N-1:0] I_ERR, I_ERR_B, I_MASK, I_CLR_SEL;
  logic         I_CLR;
  logic [N-1:0] O_ERR_STATUS;
  logic         O_IRQ, O_FATAL, O_FATAL_B;
  logic [1:0]   O_STATE;
`ifdef SAFETY_ERR_COLLECTOR_CNT_EN
  logic                I_CNT_CLR;
  logic [TB_CNT_W-1:0] O_ERR_CNT;
`endif

  always #5 ACLK = ~ACLK;

  safety_err_collector #(
    .NUM_SRC (N),
    .PERSIST (2),
    .DR_TOL  (2),
    .CNT_W   (TB_CNT_W)
  ) dut (
    .ACLK         (ACLK),
    .RESETN_ACLK  (RESETN_ACLK),
    .I_ERR        (I_ERR),
    .I_ERR_B      (I_ERR_B),
    .I_MASK       (I_MASK),
    .I_CLR        (I_CLR),
    .I_CLR_SEL    (I_CLR_SEL),
`ifdef SAFETY_ERR_COLLECTOR_CNT_EN
    .I_CNT_CLR    (I_CNT_CLR),
    .O_ERR_CNT    (O_ERR_CNT),
`endif
    .O_ERR_STATUS (O_ERR_STATUS),
    .O_IRQ        (O_IRQ),
    .O_FATAL      (O_FATAL),
    .O_FATAL_B    (O_FATAL_B),
    .O_STATE      (O_STATE)
  );

  typedef enum int {F_STATUS, F_IRQ, F_STATE, F_FATAL, F_FATAL_B, F_CNT} field_e;
  typedef struct {
    string      tag;
    field_e     field;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  function automatic logic [7:0] observe(input field_e f);
    case (f)
      F_STATUS:  return 8'(O_ERR_STATUS);
      F_IRQ:     return 8'(O_IRQ);
      F_STATE:   return 8'(O_STATE);
      F_FATAL:   return 8'(O_FATAL);
      F_FATAL_B: return 8'(O_FATAL_B);
`ifdef SAFETY_ERR_COLLECTOR_CNT_EN
      F_CNT:     return 8'(O_ERR_CNT);
`endif
      default:   return 8'hxx;
    endcase
  endfunction

  task automatic push_exp(input string tag, input field_e f, input logic [7:0] v);
    exp_t e;
    e.tag   = tag;
    e.field = f;
    e.val   = v;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t       e;
    logic [7:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.field);
      n_assert++;
      assert (o === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_pair(input int src, input logic e, input logic eb);
    I_ERR[src]   = e;
    I_ERR_B[src] = eb;
  endtask

  task automatic clean();
    I_ERR   = '0;
    I_ERR_B = '1;
  endtask

  task automatic clear(input logic [N-1:0] sel);
    I_CLR     = 1'b1;
    I_CLR_SEL = sel;
    tick();
    I_CLR     = 1'b0;
    I_CLR_SEL = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    RESETN_ACLK = 1'b0;
    clean();
    I_MASK    = '0;
    I_CLR     = 1'b0;
    I_CLR_SEL = '0;
`ifdef SAFETY_ERR_COLLECTOR_CNT_EN
    I_CNT_CLR = 1'b0;
`endif

    // Values held during reset
    push_exp("rst_status",  F_STATUS,  8'h0);
    push_exp("rst_irq",     F_IRQ,     8'h0);
    push_exp("rst_state",   F_STATE,   8'(IDLE));
    push_exp("rst_fatal",   F_FATAL,   8'h0);
    push_exp("rst_fatal_b", F_FATAL_B, 8'h1);
    ticks(2);
    check_sb();
    RESETN_ACLK = 1'b1;
    ticks(2);

    // One-cycle error pulse is filtered out
    set_pair(0, 1'b1, 1'b0);
    tick();
    clean();
    push_exp("pulse_status", F_STATUS, 8'h0);
    push_exp("pulse_irq",    F_IRQ,    8'h0);
    push_exp("pulse_state",  F_STATE,  8'(IDLE));
    ticks(4);
    check_sb();

    // Two-cycle error on source 1 latches; IRQ one cycle later
    set_pair(1, 1'b1, 1'b0);
    ticks(2);
    clean();
    push_exp("s1_status", F_STATUS, 8'h2);
    push_exp("s1_irq_0",  F_IRQ,    8'h0);
    push_exp("s1_state",  F_STATE,  8'(ERROR));
    tick();
    check_sb();
    push_exp("s1_irq_1",   F_IRQ,    8'h1);
    push_exp("s1_sticky",  F_STATUS, 8'h2);
    tick();
    check_sb();
    push_exp("s1_clr_status", F_STATUS, 8'h0);
    push_exp("s1_clr_state",  F_STATE,  8'(IDLE));
    clear(4'b0010);
    check_sb();
    push_exp("s1_clr_irq", F_IRQ, 8'h0);
    tick();
    check_sb();

    // Masked sources still latch and drive the FSM
    I_MASK = 4'b0011;
    set_pair(0, 1'b1, 1'b0);
    set_pair(1, 1'b1, 1'b0);
    ticks(2);
    clean();
    push_exp("mask_status", F_STATUS, 8'h3);
    push_exp("mask_state",  F_STATE,  8'(ERROR));
    tick();
    check_sb();
    push_exp("mask_irq",   F_IRQ,   8'h0);
    push_exp("mask_state2", F_STATE, 8'(ERROR));
    tick();
    check_sb();
    I_MASK = 4'b0001;
    push_exp("part_mask_irq", F_IRQ, 8'h1);
    tick();
    check_sb();
    I_MASK = 4'b0011;
    push_exp("mask_clr_status", F_STATUS, 8'h0);
    push_exp("mask_clr_state",  F_STATE,  8'(IDLE));
    clear(4'b0011);
    check_sb();
    push_exp("mask_clr_irq", F_IRQ, 8'h0);
    tick();
    check_sb();
    I_MASK = '0;

    // Set and clear on the same edge: set wins
    set_pair(3, 1'b1, 1'b0);
    ticks(2);
    I_CLR     = 1'b1;
    I_CLR_SEL = 4'b1000;
    push_exp("setwin_status", F_STATUS, 8'h8);
    push_exp("setwin_state",  F_STATE,  8'(ERROR));
    tick();
    I_CLR     = 1'b0;
    I_CLR_SEL = '0;
    check_sb();
    clean();
    ticks(3);
    push_exp("s3_clr_status", F_STATUS, 8'h0);
    push_exp("s3_clr_state",  F_STATE,  8'(IDLE));
    clear(4'b1000);
    check_sb();

`ifdef SAFETY_ERR_COLLECTOR_CNT_EN
    // Event counter: saturates at 3 with CNT_W=2, clear wins over increment
    I_CNT_CLR = 1'b1;
    push_exp("cnt_clr0", F_CNT, 8'h0);
    tick();
    I_CNT_CLR = 1'b0;
    check_sb();
    for (int k = 1; k <= 5; k++) begin
      set_pair(0, 1'b1, 1'b0);
      ticks(2);
      clean();
      push_exp("cnt_rise",   F_CNT,    8'((k < 3) ? k : 3));
      push_exp("cnt_status", F_STATUS, 8'h1);
      tick();
      check_sb();
      ticks(2);
      push_exp("cnt_src_clr", F_STATUS, 8'h0);
      clear(4'b0001);
      check_sb();
    end
    set_pair(0, 1'b1, 1'b0);
    ticks(2);
    clean();
    I_CNT_CLR = 1'b1;
    push_exp("cnt_clr_wins", F_CNT,    8'h0);
    push_exp("cnt_clr_stat", F_STATUS, 8'h1);
    tick();
    I_CNT_CLR = 1'b0;
    check_sb();
    ticks(2);
    clear(4'b0001);
`endif

    // Single-cycle disagreement is tolerated
    set_pair(2, 1'b1, 1'b1);
    tick();
    clean();
    push_exp("dr1_state",   F_STATE,   8'(IDLE));
    push_exp("dr1_fatal",   F_FATAL,   8'h0);
    push_exp("dr1_fatal_b", F_FATAL_B, 8'h1);
    ticks(4);
    check_sb();

    // Held disagreement on source 2 -> FATAL
    set_pair(2, 1'b1, 1'b1);
    n = 0;
    while (O_STATE !== 2'(FATAL) && n < 8) begin
      tick();
      n++;
    end
    clean();
    push_exp("fatal_state",   F_STATE,   8'(FATAL));
    push_exp("fatal_fatal",   F_FATAL,   8'h1);
    push_exp("fatal_fatal_b", F_FATAL_B, 8'h0);
    check_sb();

    // Latching and clearing continue in FATAL; state does not leave
    set_pair(1, 1'b1, 1'b0);
    ticks(2);
    clean();
    push_exp("fatal_latch", F_STATUS, 8'h2);
    push_exp("fatal_hold",  F_STATE,  8'(FATAL));
    tick();
    check_sb();
    ticks(2);
    push_exp("fatal_clr_status", F_STATUS,  8'h0);
    push_exp("fatal_clr_state",  F_STATE,   8'(FATAL));
    push_exp("fatal_clr_fb",     F_FATAL_B, 8'h0);
    clear(4'b1111);
    check_sb();

    // Asynchronous reset out of FATAL with a status bit set
    set_pair(1, 1'b1, 1'b0);
    ticks(2);
    clean();
    ticks(2);
    #3;
    RESETN_ACLK = 1'b0;
    #1;
    push_exp("arst_state",   F_STATE,   8'(IDLE));
    push_exp("arst_status",  F_STATUS,  8'h0);
    push_exp("arst_irq",     F_IRQ,     8'h0);
    push_exp("arst_fatal",   F_FATAL,   8'h0);
    push_exp("arst_fatal_b", F_FATAL_B, 8'h1);
    check_sb();
    tick();
    RESETN_ACLK = 1'b1;
    push_exp("post_rst_state",   F_STATE,   8'(IDLE));
    push_exp("post_rst_status",  F_STATUS,  8'h0);
    push_exp("post_rst_fatal_b", F_FATAL_B, 8'h1);
    ticks(3);
    check_sb();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
